// File: rtl/ecpu_bus_pkg.sv
// Shared types and constants for the ECPU Wishbone bus fabric.
package ecpu_bus_pkg;

    localparam int unsigned MASTER_IMEM  = 0;
    localparam int unsigned MASTER_DMEM  = 1;
    localparam int unsigned WB_TIMEOUT_W = 16;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/ecpu_bus_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags a timeout so the
// fabric can answer a hung slave with an error.
module ecpu_bus_watchdog
    import ecpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stall_i,
    input  logic clr_i,
    output logic timeout_hit_c_o
);

    logic [WB_TIMEOUT_W-1:0] count_q;
    logic [WB_TIMEOUT_W-1:0] count_d;

    // A zero limit disables the watchdog entirely.
    assign timeout_hit_c_o = (TIMEOUT_CYCLES != 0) &&
                             (count_q == WB_TIMEOUT_W'(TIMEOUT_CYCLES));

    always_comb begin
        count_d = count_q;
        if (clr_i || timeout_hit_c_o) begin
            count_d = '0;
        end else if (stall_i) begin
            count_d = count_q + WB_TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ecpu_wb_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter: fetch port (m0) and
// load/store port (m1) share the unified memory port; grant held for a whole CYC.
module ecpu_wb_arbiter
    import ecpu_bus_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned RR_ENABLE      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [XLEN-1:0]       m0_dat_i,
    input  logic [XLEN/8-1:0]     m0_sel_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic [XLEN-1:0]       m0_dat_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [XLEN-1:0]       m1_dat_i,
    input  logic [XLEN/8-1:0]     m1_sel_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [XLEN-1:0]       m1_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [XLEN-1:0]       s_dat_o,
    output logic [XLEN/8-1:0]     s_sel_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic [XLEN-1:0]       s_dat_i,
    output logic [1:0]            grant_o
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       wd_stall;
    logic       wd_clr;
    logic       wd_hit;

    // Winner among current requesters; a tie goes to m1 unless round-robin
    // says m1 had the bus last.
    function automatic arb_state_t arbitrate(input logic cyc0, input logic cyc1,
                                             input logic last);
        arb_state_t win;
        if (cyc0 && cyc1) begin
            win = ((RR_ENABLE != 0) && (last == 1'(MASTER_DMEM))) ? GNT0 : GNT1;
        end else if (cyc1) begin
            win = GNT1;
        end else if (cyc0) begin
            win = GNT0;
        end else begin
            win = IDLE;
        end
        return win;
    endfunction

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        s_sel_o      = '0;
        m0_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m1_ack_o     = 1'b0;
        m1_err_o     = 1'b0;
        wd_stall     = 1'b0;
        case (state_q)
            IDLE: state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_grant_q);
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~wd_hit;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_hit;
                wd_stall = m0_stb_i & ~s_ack_i & ~s_err_i;
                // Release hands straight over to a waiting master.
                if (!m0_cyc_i) begin
                    state_d      = arbitrate(m0_cyc_i, m1_cyc_i, last_grant_q);
                    last_grant_d = 1'(MASTER_IMEM);
                end
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~wd_hit;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_hit;
                wd_stall = m1_stb_i & ~s_ack_i & ~s_err_i;
                if (!m1_cyc_i) begin
                    state_d      = arbitrate(m0_cyc_i, m1_cyc_i, last_grant_q);
                    last_grant_d = 1'(MASTER_DMEM);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'(MASTER_DMEM);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o  = 2'(state_q);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign wd_clr   = (state_d != state_q) | s_ack_i | s_err_i;

    ecpu_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .stall_i        (wd_stall),
        .clr_i          (wd_clr),
        .timeout_hit_c_o(wd_hit)
    );

endmodule

// File: tb/tb_ecpu_wb_arbiter.sv
// Directed bench for ecpu_wb_arbiter: three instances (fixed/TO=8, RR/TO=8,
// fixed/watchdog off) share the same stimulus.
module tb_ecpu_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_wd;
    logic [3:0]  m0_sel;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_wd;
    logic [3:0]  m1_sel;
    logic        s_ack, s_err;
    logic [31:0] s_rd;

    logic        m0_ack [3];
    logic        m0_err [3];
    logic [31:0] m0_rd  [3];
    logic        m1_ack [3];
    logic        m1_err [3];
    logic [31:0] m1_rd  [3];
    logic        s_cyc  [3];
    logic        s_stb  [3];
    logic        s_we   [3];
    logic [31:0] s_adr  [3];
    logic [31:0] s_wd   [3];
    logic [3:0]  s_sel  [3];
    logic [1:0]  grant  [3];

    int n_cmp = 0;
    int n_mis = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ecpu_wb_arbiter #(
            .XLEN          (32),
            .ADDR_WIDTH    (32),
            .RR_ENABLE     ((g == 1) ? 1 : 0),
            .TIMEOUT_CYCLES((g == 2) ? 0 : 8)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .m0_cyc_i(m0_cyc),
            .m0_stb_i(m0_stb),
            .m0_we_i (m0_we),
            .m0_adr_i(m0_adr),
            .m0_dat_i(m0_wd),
            .m0_sel_i(m0_sel),
            .m0_ack_o(m0_ack[g]),
            .m0_err_o(m0_err[g]),
            .m0_dat_o(m0_rd[g]),
            .m1_cyc_i(m1_cyc),
            .m1_stb_i(m1_stb),
            .m1_we_i (m1_we),
            .m1_adr_i(m1_adr),
            .m1_dat_i(m1_wd),
            .m1_sel_i(m1_sel),
            .m1_ack_o(m1_ack[g]),
            .m1_err_o(m1_err[g]),
            .m1_dat_o(m1_rd[g]),
            .s_cyc_o (s_cyc[g]),
            .s_stb_o (s_stb[g]),
            .s_we_o  (s_we[g]),
            .s_adr_o (s_adr[g]),
            .s_dat_o (s_wd[g]),
            .s_sel_o (s_sel[g]),
            .s_ack_i (s_ack),
            .s_err_i (s_err),
            .s_dat_i (s_rd),
            .grant_o (grant[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic [1:0]  m0;    // cyc, stb
        logic [31:0] m0a;
        logic [2:0]  m1;    // cyc, stb, we
        logic [31:0] m1a;
        logic [1:0]  rsp;   // ack, err
        logic [31:0] sdat;
        logic [1:0]  g;     // expected grant
        logic [2:0]  s;     // expected s_cyc, s_stb, s_we
        logic [31:0] adr;
        logic [3:0]  r;     // expected m0_ack, m0_err, m1_ack, m1_err
        logic [31:0] d0;
        logic [15:0] cnt;   // expected watchdog count of instance 0
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wd = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wd = '0;
        m0_sel = 4'h3; m1_sel = 4'hC;
        s_ack = 1'b0; s_err = 1'b0; s_rd = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] exp_wd;
    logic [3:0]  exp_sel;
    int          e2;
    logic        hit;

    initial begin
        // Single fetch
        vecs[0]  = '{2'b11, 32'h100, 3'b000, 32'h0,   2'b00, 32'h0,        2'b00, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[1]  = '{2'b11, 32'h100, 3'b000, 32'h0,   2'b00, 32'h0,        2'b01, 3'b110, 32'h100, 4'b0000, 32'h0,        16'd0};
        vecs[2]  = '{2'b11, 32'h100, 3'b000, 32'h0,   2'b10, 32'h13,       2'b01, 3'b110, 32'h100, 4'b1000, 32'h13,       16'd1};
        vecs[3]  = '{2'b00, 32'h0,   3'b000, 32'h0,   2'b00, 32'h0,        2'b01, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[4]  = '{2'b00, 32'h0,   3'b000, 32'h0,   2'b00, 32'h0,        2'b00, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        // Fixed priority with direct handoff
        vecs[5]  = '{2'b11, 32'h200, 3'b111, 32'h300, 2'b00, 32'h0,        2'b00, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[6]  = '{2'b11, 32'h200, 3'b111, 32'h300, 2'b00, 32'h0,        2'b10, 3'b111, 32'h300, 4'b0000, 32'h0,        16'd0};
        vecs[7]  = '{2'b11, 32'h200, 3'b111, 32'h300, 2'b10, 32'hCAFE0001, 2'b10, 3'b111, 32'h300, 4'b0010, 32'hCAFE0001, 16'd1};
        vecs[8]  = '{2'b11, 32'h200, 3'b000, 32'h0,   2'b00, 32'h0,        2'b10, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[9]  = '{2'b11, 32'h200, 3'b000, 32'h0,   2'b00, 32'h0,        2'b01, 3'b110, 32'h200, 4'b0000, 32'h0,        16'd0};
        vecs[10] = '{2'b11, 32'h200, 3'b000, 32'h0,   2'b10, 32'hDEADBEEF, 2'b01, 3'b110, 32'h200, 4'b1000, 32'hDEADBEEF, 16'd1};
        vecs[11] = '{2'b00, 32'h0,   3'b000, 32'h0,   2'b00, 32'h0,        2'b01, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[12] = '{2'b00, 32'h0,   3'b000, 32'h0,   2'b00, 32'h0,        2'b00, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        // Error passthrough
        vecs[13] = '{2'b11, 32'h400, 3'b000, 32'h0,   2'b00, 32'h0,        2'b00, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[14] = '{2'b11, 32'h400, 3'b000, 32'h0,   2'b00, 32'h0,        2'b01, 3'b110, 32'h400, 4'b0000, 32'h0,        16'd0};
        vecs[15] = '{2'b11, 32'h400, 3'b000, 32'h0,   2'b01, 32'h0,        2'b01, 3'b110, 32'h400, 4'b0100, 32'h0,        16'd1};
        vecs[16] = '{2'b00, 32'h0,   3'b000, 32'h0,   2'b00, 32'h0,        2'b01, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};
        vecs[17] = '{2'b00, 32'h0,   3'b000, 32'h0,   2'b00, 32'h0,        2'b00, 3'b000, 32'h0,   4'b0000, 32'h0,        16'd0};

        // Reset state, with requests and a stray ack present
        rst_n = 1'b0;
        idle_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_grant%0d", k), 64'(grant[k]), 64'd0);
            chk($sformatf("rst_scyc%0d", k), 64'(s_cyc[k]), 64'd0);
            chk($sformatf("rst_acks%0d", k), 64'({m0_ack[k], m1_ack[k], m0_err[k], m1_err[k]}), 64'd0);
        end
        do_reset();

        // Table-driven vectors against the fixed-priority instance
        for (int i = 0; i < NV; i++) begin
            m0_cyc = vecs[i].m0[1]; m0_stb = vecs[i].m0[0]; m0_we = 1'b0;
            m0_adr = vecs[i].m0a;   m0_wd = vecs[i].m0a ^ 32'hA5A5_0000;
            m1_cyc = vecs[i].m1[2]; m1_stb = vecs[i].m1[1]; m1_we = vecs[i].m1[0];
            m1_adr = vecs[i].m1a;   m1_wd = vecs[i].m1a ^ 32'h5A5A_0000;
            s_ack = vecs[i].rsp[1]; s_err = vecs[i].rsp[0]; s_rd = vecs[i].sdat;
            @(negedge clk);
            case (vecs[i].g)
                2'b01:   begin exp_wd = m0_wd; exp_sel = m0_sel; end
                2'b10:   begin exp_wd = m1_wd; exp_sel = m1_sel; end
                default: begin exp_wd = '0;    exp_sel = '0;     end
            endcase
            chk($sformatf("v%0d_grant", i), 64'(grant[0]), 64'(vecs[i].g));
            chk($sformatf("v%0d_sctl", i), 64'({s_cyc[0], s_stb[0], s_we[0]}), 64'(vecs[i].s));
            chk($sformatf("v%0d_sadr", i), 64'(s_adr[0]), 64'(vecs[i].adr));
            chk($sformatf("v%0d_swd", i), 64'({s_sel[0], s_wd[0]}), 64'({exp_sel, exp_wd}));
            chk($sformatf("v%0d_rsp", i), 64'({m0_ack[0], m0_err[0], m1_ack[0], m1_err[0]}), 64'(vecs[i].r));
            chk($sformatf("v%0d_rd", i), 64'({m0_rd[0], m1_rd[0]}), 64'({vecs[i].d0, vecs[i].sdat}));
            chk($sformatf("v%0d_cnt", i), 64'(g_dut[0].u_dut.u_wdog.count_q), 64'(vecs[i].cnt));
            @(posedge clk);
            #1;
        end

        // Ties from IDLE: round-robin alternates, fixed always picks m1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h700;
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h800;
            @(posedge clk); #1;
            s_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("rr%0d_grant", r), 64'(grant[1]), (r % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("rr%0d_ack", r), 64'({m0_ack[1], m1_ack[1]}), (r % 2 == 0) ? 64'd2 : 64'd1);
            chk($sformatf("fix%0d_grant", r), 64'(grant[0]), 64'd2);
            @(posedge clk); #1;
            s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            @(posedge clk); #1;
        end

        // Watchdog: m1 write to a slave that never answers
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h500;
        @(posedge clk); #1;
        e2 = 0;
        for (int s = 1; s <= 27; s++) begin
            @(negedge clk);
            hit = (s % 9 == 0);
            chk($sformatf("wd%0d_err", s), 64'({m1_err[0], m0_err[0]}), 64'({hit, 1'b0}));
            chk($sformatf("wd%0d_stb", s), 64'(s_stb[0]), 64'(!hit));
            if (m1_err[2]) e2++;
            @(posedge clk); #1;
        end
        repeat (1000) begin
            @(negedge clk);
            if (m1_err[2] || !s_stb[2]) e2++;
            @(posedge clk); #1;
        end
        chk("wd_off_err", 64'(e2), 64'd0);

        // Reset between edges during GNT0
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h600;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_grant", 64'({grant[0], grant[1]}), 64'({2'b01, 2'b01}));
        chk("pre_rst_scyc", 64'(s_cyc[0]), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0; s_ack = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mid_rst_grant%0d", k), 64'(grant[k]), 64'd0);
            chk($sformatf("mid_rst_s%0d", k), 64'({s_cyc[k], s_stb[k]}), 64'd0);
            chk($sformatf("mid_rst_ack%0d", k), 64'({m0_ack[k], m1_ack[k]}), 64'd0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1; s_ack = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rr_grant", 64'(grant[1]), 64'd1);
        chk("post_rst_fix_grant", 64'(grant[0]), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
